// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, FSM state encoding and default baud divisor.
// Optional build macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1).
package uart_pkg;

  localparam logic [2:0] TXDATA_OFF = 3'h0;
  localparam logic [2:0] STATUS_OFF = 3'h4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // 6 MHz clk / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 52;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
`endif

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s                   = '0;
    s[ST_BUSY]          = busy;
    s[ST_FULL]          = full;
    s[ST_EMPTY]         = empty;
    s[ST_OVF]           = ovf;
    s[ST_CNT_LSB +: 4]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small circular FIFO; pointers wrap naturally because DEPTH is a power of two.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage needs no reset; only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointer and occupancy bookkeeping; push+pop together leaves count alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. TXDATA (offset 0) queues a byte, STATUS
// (offset 4) reports busy/full/empty/overflow/count. Serialises LSB first.
// Optional build macro: UART_TX_PARITY_EN (8E1 frame instead of 8N1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] read_data,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ovf;

  logic          hit, push, pop, clr_ovf, baud_last;
  logic [2:0]    off;
  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;

  // bus decode; byte lanes addr[1:0] are don't-care
  assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
  assign off       = {addr[2], 2'b00};
  assign push      = memwrite && hit && (off == TXDATA_OFF);
  assign clr_ovf   = memwrite && hit && (off == STATUS_OFF) && write_data[ST_OVF];
  assign pop       = (state == S_IDLE) && !empty;
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

  // zero unless STATUS is read, so it can be OR-ed onto the shared load bus
  assign read_data = (memread && hit && (off == STATUS_OFF))
                   ? pack_status(state != S_IDLE, full, empty, ovf, 4'(count))
                   : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{write_data[31:8], addr[1:0]};

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (write_data[7:0]),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // sticky overflow: a push seen while full is lost even if a pop coincides
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ovf <= 1'b0;
    else if (push && full)   ovf <= 1'b1;
    else if (clr_ovf)        ovf <= 1'b0;
  end

  // shifter FSM; uart_tx is registered from the current state, so the line
  // trails the state by one clock and stays glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          baud    <= '0;
          bit_idx <= '0;
          if (!empty) begin
            shreg <= head;
            state <= S_START;
          end
        end
        S_START: begin
          uart_tx <= 1'b0;
          if (baud_last) begin
            baud  <= '0;
            state <= S_DATA;
          end else baud <= baud + 1'b1;
        end
        S_DATA: begin
          uart_tx <= shreg[bit_idx];
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end else baud <= baud + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          uart_tx <= ^shreg;
          if (baud_last) begin
            baud  <= '0;
            state <= S_STOP;
          end else baud <= baud + 1'b1;
        end
`endif
        S_STOP: begin
          uart_tx <= 1'b1;
          if (baud_last) begin
            baud  <= '0;
            state <= S_IDLE;
          end else baud <= baud + 1'b1;
        end
        default: begin
          uart_tx <= 1'b1;
          baud    <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
